red_seq: RTL

Program sequencer for the red core. It owns the program counter, drives the instruction ROM through a request/acknowledge handshake, and hands fetched opcodes to the decoder through a valid/ready handshake. It applies branch, call, return and halt decisions that the decoder returns with each accepted opcode. It replaces the free-running PC/opcode register pair with a stallable, restartable fetch controller that has a small hardware return stack.

---
 rtl/red_pkg.sv | 13 +
 rtl/red_ret_stack.sv | 42 ++++
 rtl/red_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/red_pkg.sv
// Shared types and default sizing for the red core program sequencer.
package red_pkg;
    localparam int RED_ADDR_W   = 8;
    localparam int RED_DATA_W   = 16;
    localparam int RED_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/red_ret_stack.sv
// Small LIFO of return addresses; push is ignored when full, pop when empty.
module red_ret_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]     r_cnt;
    logic [CW-2:0]     w_wr_idx;
    logic [CW-2:0]     w_top_idx;

    assign w_wr_idx  = r_cnt[CW-2:0];
    assign w_top_idx = r_cnt[CW-2:0] - 1'b1;
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Entry storage needs no reset: the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) r_mem[w_wr_idx] <= i_push_data;
    end
endmodule

// File: rtl/red_seq.sv
// Program sequencer: PC, ROM fetch handshake, opcode hand-off and return stack.
module red_seq
    import red_pkg::*;
#(
    parameter int ADDR_W      = RED_ADDR_W,
    parameter int DATA_W      = RED_DATA_W,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = RED_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              run,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_data,
    input  logic              op_ready,
    input  logic              br_req,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] br_target,
    output logic [1:0]        state,
    output logic              stack_err
);
    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_op;
    logic              r_rom_req;
    logic              r_op_valid;
    logic              r_stack_err;

    logic              w_accept;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;

    assign w_accept = en && r_op_valid && op_ready;
    assign w_pc_inc = r_pc + 1'b1;
    // Stack side effects follow the same priority as the next-PC mux.
    assign w_pop    = w_accept && !halt_req && ret_req && !w_empty;
    assign w_push   = w_accept && !halt_req && !ret_req && call_req && !w_full;

    red_ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_top),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= ADDR_W'(RESET_PC);
            r_op        <= '0;
            r_rom_req   <= 1'b0;
            r_op_valid  <= 1'b0;
            r_stack_err <= 1'b0;
        end else if (en) begin
            case (r_state)
                IDLE, HALT: begin
                    if (run) begin
                        r_state   <= FETCH;
                        r_rom_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_ack) begin
                        r_op       <= rom_data;
                        r_rom_req  <= 1'b0;
                        r_op_valid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_op_valid <= 1'b0;
                        r_rom_req  <= 1'b1;
                        r_state    <= FETCH;
                        if (halt_req) begin
                            r_pc      <= w_pc_inc;
                            r_rom_req <= 1'b0;
                            r_state   <= HALT;
                        end else if (ret_req) begin
                            if (!w_empty) begin
                                r_pc <= w_top;
                            end else begin
                                r_stack_err <= 1'b1;
                                r_pc        <= w_pc_inc;
                                r_rom_req   <= 1'b0;
                                r_state     <= HALT;
                            end
                        end else if (call_req) begin
                            if (w_full) r_stack_err <= 1'b1;
                            r_pc <= br_target;
                        end else if (br_req) begin
                            r_pc <= br_target;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_req   = r_rom_req;
    assign rom_addr  = r_pc;
    assign op_valid  = r_op_valid;
    assign op_data   = r_op;
    assign state     = r_state;
    assign stack_err = r_stack_err;
endmodule
